// File: rtl/fanout_fork_ctrl_if.sv
// rtl/fanout_fork_ctrl_if.sv - fork stream bundle: one upstream token, per-branch valid/ready
interface fanout_fork_ctrl_if #(
   parameter int NUM_BRANCH = 9,
   parameter int DATA_W     = 17
);
   logic                  in_valid;
   logic [DATA_W-1:0]     in_data;
   logic                  in_ready;
   logic [NUM_BRANCH-1:0] out_valid;
   logic [DATA_W-1:0]     out_data;
   logic [NUM_BRANCH-1:0] out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fanout_fork_ctrl.sv
// rtl/fanout_fork_ctrl.sv - eager fork controller with token-safe mask reconfiguration
// Optional FANOUT_FORK_TOKEN_CNT_EN adds tok_cnt_o/drop_cnt_o completion counters.
module fanout_fork_ctrl #(
   parameter int                    NUM_BRANCH = 9,
   parameter int                    DATA_W     = 17,
   parameter logic [NUM_BRANCH-1:0] EN_RST     = '0,
   parameter logic [NUM_BRANCH-1:0] SEL_RST    = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fanout_fork_ctrl_if.slave     s_if,
`ifdef FANOUT_FORK_TOKEN_CNT_EN
   output logic [31:0]           tok_cnt_o,
   output logic [31:0]           drop_cnt_o,
`endif
   input  logic                  cfg_wr_i,
   input  logic [NUM_BRANCH-1:0] cfg_en_i,
   input  logic [NUM_BRANCH-1:0] cfg_sel_i,
   output logic                  cfg_busy_o,
   output logic [NUM_BRANCH-1:0] active_mask_o
);

   typedef enum logic [1:0] {IDLE, PART, RECFG} state_t;

   state_t                state_q, state_d;
   logic [NUM_BRANCH-1:0] en_q, en_d, sel_q, sel_d;
   logic [NUM_BRANCH-1:0] pend_en_q, pend_en_d, pend_sel_q, pend_sel_d;
   logic [NUM_BRANCH-1:0] done_q, done_d;
   logic [NUM_BRANCH-1:0] act, fire;
   logic [DATA_W-1:0]     data;
   logic                  fire_all, part_fire, apply;

   assign act  = en_q & sel_q;
   assign data = s_if.in_data;

   // rst_n is folded into the handshake so nothing fires while reset is held
   assign s_if.out_valid = {NUM_BRANCH{s_if.in_valid & rst_n}} & act & ~done_q;
   assign s_if.in_ready  = rst_n & (&(~act | done_q | s_if.out_ready));
   assign s_if.out_data  = data;

   assign fire      = s_if.out_valid & s_if.out_ready;
   assign fire_all  = s_if.in_valid & s_if.in_ready;
   assign part_fire = ~fire_all & (|fire);

   assign cfg_busy_o    = (state_q == RECFG);
   assign active_mask_o = act;

   always_comb begin
      state_d    = state_q;
      en_d       = en_q;
      sel_d      = sel_q;
      pend_en_d  = pend_en_q;
      pend_sel_d = pend_sel_q;
      apply      = 1'b0;
      done_d     = fire_all ? '0 : (done_q | fire);

      case (state_q)
         IDLE: begin
            if (part_fire) begin
               state_d = PART;
               if (cfg_wr_i) begin
                  pend_en_d  = cfg_en_i;
                  pend_sel_d = cfg_sel_i;
                  state_d    = RECFG;
               end
            end else if (cfg_wr_i) begin
               en_d  = cfg_en_i;
               sel_d = cfg_sel_i;
               apply = 1'b1;
            end
         end
         PART: begin
            if (fire_all) begin
               state_d = IDLE;
               if (cfg_wr_i) begin
                  en_d  = cfg_en_i;
                  sel_d = cfg_sel_i;
                  apply = 1'b1;
               end
            end else if (cfg_wr_i) begin
               pend_en_d  = cfg_en_i;
               pend_sel_d = cfg_sel_i;
               state_d    = RECFG;
            end
         end
         RECFG: begin
            // a write landing on the completing cycle is newer than the held one
            if (fire_all) begin
               state_d = IDLE;
               en_d    = cfg_wr_i ? cfg_en_i  : pend_en_q;
               sel_d   = cfg_wr_i ? cfg_sel_i : pend_sel_q;
               apply   = 1'b1;
            end else if (cfg_wr_i) begin
               pend_en_d  = cfg_en_i;
               pend_sel_d = cfg_sel_i;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         en_q       <= EN_RST;
         sel_q      <= SEL_RST;
         pend_en_q  <= '0;
         pend_sel_q <= '0;
         done_q     <= '0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         sel_q      <= sel_d;
         pend_en_q  <= pend_en_d;
         pend_sel_q <= pend_sel_d;
         done_q     <= done_d;
      end
   end

`ifdef FANOUT_FORK_TOKEN_CNT_EN
   logic [31:0] tok_cnt_q, tok_cnt_d, drop_cnt_q, drop_cnt_d;

   // a mask change restarts both counts, including a token completing on that edge
   always_comb begin
      tok_cnt_d  = tok_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (apply) begin
         tok_cnt_d  = '0;
         drop_cnt_d = '0;
      end else if (fire_all) begin
         if (|act) tok_cnt_d  = tok_cnt_q + 32'd1;
         else      drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         tok_cnt_q  <= tok_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign tok_cnt_o  = tok_cnt_q;
   assign drop_cnt_o = drop_cnt_q;
`else
   logic unused_apply;
   assign unused_apply = apply;
`endif

   hold_valid_a: assert property (@(posedge clk) disable iff (!rst_n)
      (|done_q) |-> s_if.in_valid)
      else $error("in_valid dropped while a token was partially accepted");

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// tb/tb_fanout_fork_ctrl.sv - vector table, reset corner cases and randomized model check
module tb_fanout_fork_ctrl;
   localparam int NB = 9;
   localparam int DW = 17;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_wr;
   logic [NB-1:0] cfg_en, cfg_sel;
   logic          cfg_busy;
   logic [NB-1:0] active_mask;
`ifdef FANOUT_FORK_TOKEN_CNT_EN
   logic [31:0]   tok_cnt, drop_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   fanout_fork_ctrl_if #(.NUM_BRANCH(NB), .DATA_W(DW)) bus ();

   fanout_fork_ctrl #(.NUM_BRANCH(NB), .DATA_W(DW), .EN_RST('0), .SEL_RST('0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_if         (bus),
`ifdef FANOUT_FORK_TOKEN_CNT_EN
      .tok_cnt_o    (tok_cnt),
      .drop_cnt_o   (drop_cnt),
`endif
      .cfg_wr_i     (cfg_wr),
      .cfg_en_i     (cfg_en),
      .cfg_sel_i    (cfg_sel),
      .cfg_busy_o   (cfg_busy),
      .active_mask_o(active_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          in_valid;
      logic [NB-1:0] out_ready;
      logic          cfg_wr;
      logic [NB-1:0] cfg_en;
      logic [NB-1:0] cfg_sel;
      logic [NB-1:0] exp_ov;
      logic          exp_ir;
      logic          exp_busy;
      logic [NB-1:0] exp_act;
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t mk(logic iv, logic [NB-1:0] ordy, logic cw, logic [NB-1:0] ce,
                               logic [NB-1:0] cs, logic [NB-1:0] eov, logic eir,
                               logic ebusy, logic [NB-1:0] eact);
      vec_t v;
      v.in_valid = iv; v.out_ready = ordy; v.cfg_wr = cw; v.cfg_en = ce; v.cfg_sel = cs;
      v.exp_ov = eov; v.exp_ir = eir; v.exp_busy = ebusy; v.exp_act = eact;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // token-level reference: a mask write takes effect only between tokens
   logic [NB-1:0] m_en, m_sel, m_pend_en, m_pend_sel, m_taken;
   bit            m_pend;
   int unsigned   m_tok, m_drop;

   task automatic model_reset();
      m_en = '0; m_sel = '0; m_pend_en = '0; m_pend_sel = '0; m_taken = '0;
      m_pend = 0; m_tok = 0; m_drop = 0;
   endtask

   function automatic logic [NB-1:0] model_ov();
      logic [NB-1:0] r;
      for (int i = 0; i < NB; i++)
         r[i] = bus.in_valid && m_en[i] && m_sel[i] && !m_taken[i];
      return r;
   endfunction

   function automatic logic model_ir();
      logic ok = 1'b1;
      for (int i = 0; i < NB; i++)
         if (m_en[i] && m_sel[i] && !m_taken[i] && !bus.out_ready[i]) ok = 1'b0;
      return ok;
   endfunction

   task automatic model_step();
      logic [NB-1:0] fire;
      logic          complete, mid, applied;
      fire     = model_ov() & bus.out_ready;
      complete = bus.in_valid && model_ir();
      mid      = !complete && ((m_taken | fire) != '0);
      applied  = 1'b0;
      if (complete) begin
         if ((m_en & m_sel) != '0) m_tok++;
         else                      m_drop++;
      end
      if (cfg_wr) begin
         if (mid) begin
            m_pend_en = cfg_en; m_pend_sel = cfg_sel; m_pend = 1;
         end else begin
            m_en = cfg_en; m_sel = cfg_sel; m_pend = 0; applied = 1'b1;
         end
      end else if (complete && m_pend) begin
         m_en = m_pend_en; m_sel = m_pend_sel; m_pend = 0; applied = 1'b1;
      end
      if (applied) begin
         m_tok = 0; m_drop = 0;
      end
      m_taken = complete ? '0 : (m_taken | fire);
   endtask

   initial begin
      logic hold;
      logic [NB-1:0] r;

      vecs[0]  = mk(0, 9'h000, 1, 9'h1FF, 9'h005, 9'h000, 1, 0, 9'h000);
      vecs[1]  = mk(1, 9'h1FF, 0, 9'h000, 9'h000, 9'h005, 1, 0, 9'h005);
      vecs[2]  = mk(0, 9'h000, 1, 9'h007, 9'h007, 9'h000, 0, 0, 9'h005);
      vecs[3]  = mk(1, 9'h001, 0, 9'h000, 9'h000, 9'h007, 0, 0, 9'h007);
      vecs[4]  = mk(1, 9'h004, 0, 9'h000, 9'h000, 9'h006, 0, 0, 9'h007);
      vecs[5]  = mk(1, 9'h002, 0, 9'h000, 9'h000, 9'h002, 1, 0, 9'h007);
      vecs[6]  = mk(1, 9'h001, 0, 9'h000, 9'h000, 9'h007, 0, 0, 9'h007);
      vecs[7]  = mk(1, 9'h000, 1, 9'h018, 9'h018, 9'h006, 0, 0, 9'h007);
      vecs[8]  = mk(1, 9'h000, 0, 9'h000, 9'h000, 9'h006, 0, 1, 9'h007);
      vecs[9]  = mk(1, 9'h006, 0, 9'h000, 9'h000, 9'h006, 1, 1, 9'h007);
      vecs[10] = mk(0, 9'h000, 0, 9'h000, 9'h000, 9'h000, 0, 0, 9'h018);
      vecs[11] = mk(1, 9'h008, 0, 9'h000, 9'h000, 9'h018, 0, 0, 9'h018);
      vecs[12] = mk(1, 9'h000, 1, 9'h003, 9'h003, 9'h010, 0, 0, 9'h018);
      vecs[13] = mk(1, 9'h000, 1, 9'h00C, 9'h00C, 9'h010, 0, 1, 9'h018);
      vecs[14] = mk(1, 9'h010, 0, 9'h000, 9'h000, 9'h010, 1, 1, 9'h018);
      vecs[15] = mk(0, 9'h000, 0, 9'h000, 9'h000, 9'h000, 0, 0, 9'h00C);
      vecs[16] = mk(0, 9'h000, 1, 9'h1FF, 9'h000, 9'h000, 0, 0, 9'h00C);
      vecs[17] = mk(1, 9'h000, 0, 9'h000, 9'h000, 9'h000, 1, 0, 9'h000);
      vecs[18] = mk(1, 9'h000, 0, 9'h000, 9'h000, 9'h000, 1, 0, 9'h000);
      vecs[19] = mk(1, 9'h000, 0, 9'h000, 9'h000, 9'h000, 1, 0, 9'h000);
      vecs[20] = mk(0, 9'h000, 1, 9'h007, 9'h007, 9'h000, 1, 0, 9'h000);
      vecs[21] = mk(1, 9'h001, 1, 9'h030, 9'h030, 9'h007, 0, 0, 9'h007);
      vecs[22] = mk(1, 9'h006, 1, 9'h0C0, 9'h0C0, 9'h006, 1, 1, 9'h007);
      vecs[23] = mk(0, 9'h000, 0, 9'h000, 9'h000, 9'h000, 0, 0, 9'h0C0);

      rst_n = 1'b0; cfg_wr = 1'b0; cfg_en = '0; cfg_sel = '0;
      bus.in_valid = 1'b1; bus.in_data = 17'h00A5; bus.out_ready = '1;
      #12;
      chk("rst in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst cfg_busy", 32'(cfg_busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; bus.in_valid = 1'b0;
      tick();
      chk("post-rst active_mask", 32'(active_mask), 32'd0);
      chk("post-rst cfg_busy", 32'(cfg_busy), 32'd0);
      chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 24; i++) begin
         bus.in_valid = vecs[i].in_valid; bus.out_ready = vecs[i].out_ready;
         cfg_wr = vecs[i].cfg_wr; cfg_en = vecs[i].cfg_en; cfg_sel = vecs[i].cfg_sel;
         @(negedge clk);
         chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
         chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ir));
         chk($sformatf("vec%0d cfg_busy", i), 32'(cfg_busy), 32'(vecs[i].exp_busy));
         chk($sformatf("vec%0d active_mask", i), 32'(active_mask), 32'(vecs[i].exp_act));
         chk($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'h00A5);
`ifdef FANOUT_FORK_TOKEN_CNT_EN
         if (i == 20) begin
            chk("zero-mask drop_cnt", drop_cnt, 32'd3);
            chk("zero-mask tok_cnt", tok_cnt, 32'd0);
         end
`endif
         @(posedge clk);
         #1;
      end

      // asynchronous reset in the middle of a partially accepted token
      bus.in_valid = 1'b0; cfg_wr = 1'b1; cfg_en = 9'h003; cfg_sel = 9'h003;
      tick();
      cfg_wr = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 9'h002;
      tick();
      bus.out_ready = '0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; bus.in_valid = 1'b0;
      tick();
      chk("midrst active_mask", 32'(active_mask), 32'd0);
      chk("midrst cfg_busy", 32'(cfg_busy), 32'd0);
      cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0; bus.in_valid = 1'b1;
      @(negedge clk);
      chk("midrst idle cfg_busy", 32'(cfg_busy), 32'd0);
      chk("midrst idle active", 32'(active_mask), 32'h003);
      chk("midrst done cleared", 32'(bus.out_valid), 32'h003);
      @(posedge clk);
      #1;

      // randomized traffic against the token-level model
      rst_n = 1'b0; bus.in_valid = 1'b0; cfg_wr = 1'b0;
      #3;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      hold = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!hold && m_taken == '0) begin
            bus.in_valid = ($urandom_range(0, 99) < 70);
            bus.in_data  = DW'($urandom);
         end else begin
            bus.in_valid = 1'b1;
         end
         bus.out_ready = NB'($urandom);
         cfg_wr  = ($urandom_range(0, 9) == 0);
         r       = NB'($urandom);
         cfg_en  = r | NB'($urandom);
         cfg_sel = NB'($urandom) | NB'($urandom);
         @(negedge clk);
         chk("rnd out_valid", 32'(bus.out_valid), 32'(model_ov()));
         chk("rnd in_ready", 32'(bus.in_ready), 32'(model_ir()));
         chk("rnd out_data", 32'(bus.out_data), 32'(bus.in_data));
         chk("rnd cfg_busy", 32'(cfg_busy), 32'(m_pend));
         chk("rnd active_mask", 32'(active_mask), 32'(m_en & m_sel));
`ifdef FANOUT_FORK_TOKEN_CNT_EN
         chk("rnd tok_cnt", tok_cnt, m_tok);
         chk("rnd drop_cnt", drop_cnt, m_drop);
`endif
         hold = bus.in_valid && !model_ir();
         @(posedge clk);
         model_step();
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
